// File: rtl/serial_carry_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder evaluation per clock,
// carry held in a flip-flop between bits, start/done handshake.
module serial_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] ss_q;
    logic [WIDTH-1:0] ss_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_cy;
    logic             last_bit;

    // Full-adder stage on the current LSBs and the stored carry.
    always_comb begin
        fa_s     = sa_q[0] ^ sb_q[0] ^ carry_q;
        fa_cy    = (sa_q[0] & sb_q[0]) | (sb_q[0] & carry_q) |
                   (sa_q[0] & carry_q);
        ss_d     = {fa_s, ss_q[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Control FSM and datapath registers; outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ss_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        carry_q <= cin;
                        ss_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    ss_q    <= ss_d;
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    carry_q <= fa_cy;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum_q   <= ss_d;
                        cout_q  <= fa_cy;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
